// File: rtl/branch_resolve_if.sv
// Execute/writeback resolve bundle: resolved branch in, redirect and predictor training out.
interface branch_resolve_if;
    logic        res_valid;
    logic        res_accept;
    logic [31:0] res_pc;
    logic [31:0] res_inst;
    logic        res_is_jump;
    logic        res_is_cond;
    logic        res_pred_taken;
    logic [31:0] res_pred_target;
    logic        res_act_taken;
    logic [31:0] res_act_target;
    logic        ex_en;
    logic        ertn_flush;
    logic        predict_error;
    logic [31:0] redirect_pc;
    logic [98:0] PB_BUS;
    logic [31:0] br_cnt;
    logic [31:0] miss_cnt;

    modport master (
        output res_valid, res_accept, res_pc, res_inst, res_is_jump, res_is_cond,
               res_pred_taken, res_pred_target, res_act_taken, res_act_target,
               ex_en, ertn_flush,
        input  predict_error, redirect_pc, PB_BUS, br_cnt, miss_cnt
    );

    modport slave (
        input  res_valid, res_accept, res_pc, res_inst, res_is_jump, res_is_cond,
               res_pred_taken, res_pred_target, res_act_taken, res_act_target,
               ex_en, ertn_flush,
        output predict_error, redirect_pc, PB_BUS, br_cnt, miss_cnt
    );
endinterface

// File: rtl/branch_resolve.sv
// Branch resolution: compares resolved control flow against the carried prediction,
// raises the redirect pulse, trains the predictors and drops wrong-path resolves.
module branch_resolve #(
    parameter int KILL_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rstn,
    branch_resolve_if.slave  bus
);
    localparam int KW = (KILL_CYCLES > 0) ? $clog2(KILL_CYCLES + 1) : 1;
    localparam logic [KW-1:0] K_LOAD = KW'(KILL_CYCLES);
    localparam logic [KW-1:0] K_ONE  = KW'(1);
    localparam logic [KW-1:0] K_ZERO = KW'(0);

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_KILL = 1'b1} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [KW-1:0] r_kcnt;
    logic [KW-1:0] w_kcnt_next;

    logic        w_fire;
    logic        w_flush;
    logic        w_kill_active;
    logic        w_live;
    logic        w_miss;
    logic        w_live_miss;
    logic [31:0] w_redirect;

    logic        r_predict_error;
    logic [31:0] r_redirect_pc;
    logic [31:0] r_inst;
    logic        r_direct_jump;
    logic        r_indirect_jump;
    logic        r_br_taken;
    logic [31:0] r_br_target;
    logic [31:0] r_pc;
    logic [31:0] r_br_cnt;
    logic [31:0] r_miss_cnt;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Qualify the resolve and detect direction/target mispredicts
    always_comb begin
        w_fire      = bus.res_valid & bus.res_accept & (bus.res_is_jump | bus.res_is_cond);
        w_flush     = bus.ex_en | bus.ertn_flush;
        w_live      = w_fire & ~w_kill_active & ~w_flush;
        w_miss      = (bus.res_pred_taken != bus.res_act_taken) ||
                      (bus.res_act_taken && (bus.res_pred_target != bus.res_act_target));
        w_live_miss = w_live & w_miss;
        if (bus.res_act_taken) begin
            w_redirect = bus.res_act_target;
        end else begin
            w_redirect = bus.res_pc + 32'd4;
        end
    end

    // Kill-window state register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_RUN;
            r_kcnt  <= K_ZERO;
        end else begin
            r_state <= w_state_next;
            r_kcnt  <= w_kcnt_next;
        end
    end

    // Kill-window next state; the window spans exactly KILL_CYCLES cycles after a redirect
    always_comb begin
        w_state_next = r_state;
        w_kcnt_next  = r_kcnt;
        if (w_flush) begin
            w_state_next = ST_RUN;
            w_kcnt_next  = K_ZERO;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_live_miss && (KILL_CYCLES > 0)) begin
                        w_state_next = ST_KILL;
                        w_kcnt_next  = K_LOAD;
                    end else begin
                        w_state_next = ST_RUN;
                        w_kcnt_next  = K_ZERO;
                    end
                end
                ST_KILL: begin
                    if (r_kcnt <= K_ONE) begin
                        w_state_next = ST_RUN;
                        w_kcnt_next  = K_ZERO;
                    end else begin
                        w_state_next = ST_KILL;
                        w_kcnt_next  = r_kcnt - K_ONE;
                    end
                end
                default: begin
                    w_state_next = ST_RUN;
                    w_kcnt_next  = K_ZERO;
                end
            endcase
        end
    end

    // Kill-window decode
    always_comb begin
        w_kill_active = (r_state == ST_KILL);
    end

    // Redirect pulse, training record and saturating performance counters
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_predict_error <= 1'b0;
            r_redirect_pc   <= 32'd0;
            r_inst          <= 32'd0;
            r_direct_jump   <= 1'b0;
            r_indirect_jump <= 1'b0;
            r_br_taken      <= 1'b0;
            r_br_target     <= 32'd0;
            r_pc            <= 32'd0;
            r_br_cnt        <= 32'd0;
            r_miss_cnt      <= 32'd0;
        end else begin
            r_predict_error <= w_live_miss;
            r_direct_jump   <= w_live & bus.res_is_jump;
            r_indirect_jump <= w_live & bus.res_is_cond & ~bus.res_is_jump;
            if (w_live_miss) begin
                r_redirect_pc <= w_redirect;
                r_miss_cnt    <= sat_inc(r_miss_cnt);
            end
            if (w_live) begin
                r_inst      <= bus.res_inst;
                r_br_taken  <= bus.res_act_taken;
                r_br_target <= bus.res_act_target;
                r_pc        <= bus.res_pc;
                r_br_cnt    <= sat_inc(r_br_cnt);
            end
        end
    end

    assign bus.predict_error = r_predict_error;
    assign bus.redirect_pc   = r_redirect_pc;
    assign bus.PB_BUS        = {r_inst, r_direct_jump, r_indirect_jump, r_br_taken, r_br_target, r_pc};
    assign bus.br_cnt        = r_br_cnt;
    assign bus.miss_cnt      = r_miss_cnt;
endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: expected records are queued at stimulus time
// and compared against the registered outputs one cycle later.
module tb_branch_resolve;
    logic clk = 1'b0;
    logic rstn;

    always #5 clk = ~clk;

    branch_resolve_if bus();

    branch_resolve #(.KILL_CYCLES(2)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    typedef struct packed {
        logic        pe;
        logic [31:0] rpc;
        logic [31:0] inst;
        logic        dj;
        logic        ij;
        logic        tk;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic [31:0] br;
        logic [31:0] miss;
    } obs_t;

    localparam logic [31:0] I_B   = 32'h5000_0040;
    localparam logic [31:0] I_BL  = 32'h5400_0100;
    localparam logic [31:0] I_BEQ = 32'h5800_0000;

    obs_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic obs_t mk(input logic pe, input logic [31:0] rpc, input logic [31:0] inst,
                                input logic dj, input logic ij, input logic tk,
                                input logic [31:0] tgt, input logic [31:0] pc,
                                input logic [31:0] br, input logic [31:0] miss);
        obs_t o;
        o.pe = pe; o.rpc = rpc; o.inst = inst; o.dj = dj; o.ij = ij; o.tk = tk;
        o.tgt = tgt; o.pc = pc; o.br = br; o.miss = miss;
        return o;
    endfunction

    function automatic obs_t snap();
        obs_t o;
        o.pe   = bus.predict_error;
        o.rpc  = bus.redirect_pc;
        o.inst = bus.PB_BUS[98:67];
        o.dj   = bus.PB_BUS[66];
        o.ij   = bus.PB_BUS[65];
        o.tk   = bus.PB_BUS[64];
        o.tgt  = bus.PB_BUS[63:32];
        o.pc   = bus.PB_BUS[31:0];
        o.br   = bus.br_cnt;
        o.miss = bus.miss_cnt;
        return o;
    endfunction

    task automatic clear_inputs();
        bus.res_valid = 1'b0; bus.res_accept = 1'b0;
        bus.res_pc = 32'd0; bus.res_inst = 32'd0;
        bus.res_is_jump = 1'b0; bus.res_is_cond = 1'b0;
        bus.res_pred_taken = 1'b0; bus.res_pred_target = 32'd0;
        bus.res_act_taken = 1'b0; bus.res_act_target = 32'd0;
        bus.ex_en = 1'b0; bus.ertn_flush = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rstn = 1'b0;
        clear_inputs();
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // One accepted resolve; returns just after the sampling edge.
    task automatic send(input logic [31:0] pc, input logic [31:0] inst, input logic j, input logic c,
                        input logic pt, input logic [31:0] ptgt, input logic at, input logic [31:0] atgt,
                        input logic ex, input logic er);
        @(negedge clk);
        bus.res_valid = 1'b1; bus.res_accept = 1'b1;
        bus.res_pc = pc; bus.res_inst = inst;
        bus.res_is_jump = j; bus.res_is_cond = c;
        bus.res_pred_taken = pt; bus.res_pred_target = ptgt;
        bus.res_act_taken = at; bus.res_act_target = atgt;
        bus.ex_en = ex; bus.ertn_flush = er;
        @(posedge clk);
        #1;
        bus.res_valid = 1'b0; bus.res_accept = 1'b0;
        bus.ex_en = 1'b0; bus.ertn_flush = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.res_valid = 1'b0; bus.res_accept = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t e, o;
        @(negedge clk);
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.res_valid = 1'($urandom_range(0, 1)); bus.res_accept = 1'($urandom_range(0, 1));
            bus.res_pc = $urandom; bus.res_inst = $urandom;
            bus.res_is_jump = 1'($urandom_range(0, 1)); bus.res_is_cond = 1'($urandom_range(0, 1));
            bus.res_pred_taken = 1'($urandom_range(0, 1)); bus.res_pred_target = $urandom;
            bus.res_act_taken = 1'($urandom_range(0, 1)); bus.res_act_target = $urandom;
            bus.ex_en = 1'($urandom_range(0, 1)); bus.ertn_flush = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            @(negedge clk);
        end
        exp_q.push_back(mk(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0));
        e = exp_q.pop_front(); o = snap(); checks++;
        if (o !== e) begin errors++; $display("FAIL reset_state got=%h exp=%h", o, e); end
        rstn = 1'b1;
        clear_inputs();
        exp_q.push_back(mk(1'b0, 32'd0, I_B, 1'b1, 1'b0, 1'b1, 32'h1C00_0040, 32'h1C00_0000, 32'd1, 32'd0));
        send(32'h1C00_0000, I_B, 1'b1, 1'b0, 1'b1, 32'h1C00_0040, 1'b1, 32'h1C00_0040, 1'b0, 1'b0);
        e = exp_q.pop_front(); o = snap(); checks++;
        if (o !== e) begin errors++; $display("FAIL reset_first_b got=%h exp=%h", o, e); end
    endtask

    task automatic test_btb_miss();
        obs_t e, o;
        apply_reset();
        exp_q.push_back(mk(1'b1, 32'h1C00_0100, I_BL, 1'b1, 1'b0, 1'b1, 32'h1C00_0100, 32'h1C00_0010, 32'd1, 32'd1));
        send(32'h1C00_0010, I_BL, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h1C00_0100, 1'b0, 1'b0);
        e = exp_q.pop_front(); o = snap(); checks++;
        if (o !== e) begin errors++; $display("FAIL btb_miss_redirect got=%h exp=%h", o, e); end
        for (int k = 1; k <= 2; k++) begin
            exp_q.push_back(mk(1'b0, 32'h1C00_0100, I_BL, 1'b0, 1'b0, 1'b1, 32'h1C00_0100, 32'h1C00_0010, 32'd1, 32'd1));
            send(32'h1C00_0010 + 32'(k * 16), I_B, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h1C00_0200, 1'b0, 1'b0);
            e = exp_q.pop_front(); o = snap(); checks++;
            if (o !== e) begin errors++; $display("FAIL btb_miss_kill_t%0d got=%h exp=%h", k, o, e); end
        end
        exp_q.push_back(mk(1'b0, 32'h1C00_0100, I_B, 1'b1, 1'b0, 1'b1, 32'h1C00_0300, 32'h1C00_0040, 32'd2, 32'd1));
        send(32'h1C00_0040, I_B, 1'b1, 1'b0, 1'b1, 32'h1C00_0300, 1'b1, 32'h1C00_0300, 1'b0, 1'b0);
        e = exp_q.pop_front(); o = snap(); checks++;
        if (o !== e) begin errors++; $display("FAIL btb_miss_live_t3 got=%h exp=%h", o, e); end
    endtask

    task automatic test_not_taken();
        obs_t e, o;
        apply_reset();
        exp_q.push_back(mk(1'b1, 32'h1C00_1000, I_BEQ, 1'b0, 1'b1, 1'b0, 32'h1C00_0800, 32'h1C00_0FFC, 32'd1, 32'd1));
        send(32'h1C00_0FFC, I_BEQ, 1'b0, 1'b1, 1'b1, 32'h1C00_0800, 1'b0, 32'h1C00_0800, 1'b0, 1'b0);
        e = exp_q.pop_front(); o = snap(); checks++;
        if (o !== e) begin errors++; $display("FAIL not_taken_redirect got=%h exp=%h", o, e); end
        idle();
        idle();
        exp_q.push_back(mk(1'b0, 32'h1C00_1000, I_B, 1'b1, 1'b0, 1'b1, 32'h1C00_2100, 32'h1C00_2000, 32'd2, 32'd1));
        send(32'h1C00_2000, I_B, 1'b1, 1'b1, 1'b1, 32'h1C00_2100, 1'b1, 32'h1C00_2100, 1'b0, 1'b0);
        e = exp_q.pop_front(); o = snap(); checks++;
        if (o !== e) begin errors++; $display("FAIL class_conflict got=%h exp=%h", o, e); end
    endtask

    task automatic test_stall();
        obs_t e, o;
        int pulses;
        pulses = 0;
        apply_reset();
        @(negedge clk);
        bus.res_valid = 1'b1; bus.res_accept = 1'b0;
        bus.res_pc = 32'h1C00_3000; bus.res_inst = I_B;
        bus.res_is_jump = 1'b1; bus.res_is_cond = 1'b0;
        bus.res_pred_taken = 1'b1; bus.res_pred_target = 32'h1C00_3040;
        bus.res_act_taken = 1'b1; bus.res_act_target = 32'h1C00_3040;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (bus.PB_BUS[66]) pulses++;
        end
        @(negedge clk);
        bus.res_accept = 1'b1;
        @(posedge clk);
        #1;
        bus.res_valid = 1'b0; bus.res_accept = 1'b0;
        if (bus.PB_BUS[66]) pulses++;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (bus.PB_BUS[66]) pulses++;
        end
        checks++;
        if (pulses !== 1) begin errors++; $display("FAIL stall_pulses got=%0d exp=1", pulses); end
        exp_q.push_back(mk(1'b0, 32'd0, I_B, 1'b0, 1'b0, 1'b1, 32'h1C00_3040, 32'h1C00_3000, 32'd1, 32'd0));
        e = exp_q.pop_front(); o = snap(); checks++;
        if (o !== e) begin errors++; $display("FAIL stall_state got=%h exp=%h", o, e); end
    endtask

    task automatic test_flush();
        obs_t e, o;
        apply_reset();
        exp_q.push_back(mk(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0));
        send(32'h1C00_4000, I_BL, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h1C00_4100, 1'b1, 1'b0);
        e = exp_q.pop_front(); o = snap(); checks++;
        if (o !== e) begin errors++; $display("FAIL flush_ex_en got=%h exp=%h", o, e); end
        exp_q.push_back(mk(1'b1, 32'h1C00_4100, I_BL, 1'b1, 1'b0, 1'b1, 32'h1C00_4100, 32'h1C00_4000, 32'd1, 32'd1));
        send(32'h1C00_4000, I_BL, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h1C00_4100, 1'b0, 1'b0);
        e = exp_q.pop_front(); o = snap(); checks++;
        if (o !== e) begin errors++; $display("FAIL flush_live_miss got=%h exp=%h", o, e); end
        exp_q.push_back(mk(1'b0, 32'h1C00_4100, I_BL, 1'b0, 1'b0, 1'b1, 32'h1C00_4100, 32'h1C00_4000, 32'd1, 32'd1));
        send(32'h1C00_4010, I_BL, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h1C00_4500, 1'b0, 1'b1);
        e = exp_q.pop_front(); o = snap(); checks++;
        if (o !== e) begin errors++; $display("FAIL flush_ertn_drop got=%h exp=%h", o, e); end
        exp_q.push_back(mk(1'b0, 32'h1C00_4100, I_B, 1'b1, 1'b0, 1'b1, 32'h1C00_4600, 32'h1C00_4020, 32'd2, 32'd1));
        send(32'h1C00_4020, I_B, 1'b1, 1'b0, 1'b1, 32'h1C00_4600, 1'b1, 32'h1C00_4600, 1'b0, 1'b0);
        e = exp_q.pop_front(); o = snap(); checks++;
        if (o !== e) begin errors++; $display("FAIL flush_after_ertn_live got=%h exp=%h", o, e); end
    endtask

    task automatic test_back_to_back();
        obs_t e, o;
        apply_reset();
        exp_q.push_back(mk(1'b0, 32'd0, I_BEQ, 1'b0, 1'b1, 1'b0, 32'h1C00_5800, 32'h1C00_5000, 32'd1, 32'd0));
        exp_q.push_back(mk(1'b0, 32'd0, I_B, 1'b1, 1'b0, 1'b1, 32'h1C00_5900, 32'h1C00_5004, 32'd2, 32'd0));
        exp_q.push_back(mk(1'b0, 32'd0, I_BEQ, 1'b0, 1'b1, 1'b1, 32'h1C00_5A00, 32'h1C00_5008, 32'd3, 32'd0));
        exp_q.push_back(mk(1'b0, 32'd0, I_BEQ, 1'b0, 1'b0, 1'b1, 32'h1C00_5A00, 32'h1C00_5008, 32'd3, 32'd0));
        send(32'h1C00_5000, I_BEQ, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'h1C00_5800, 1'b0, 1'b0);
        e = exp_q.pop_front(); o = snap(); checks++;
        if (o !== e) begin errors++; $display("FAIL b2b_first got=%h exp=%h", o, e); end
        send(32'h1C00_5004, I_B, 1'b1, 1'b0, 1'b1, 32'h1C00_5900, 1'b1, 32'h1C00_5900, 1'b0, 1'b0);
        e = exp_q.pop_front(); o = snap(); checks++;
        if (o !== e) begin errors++; $display("FAIL b2b_second got=%h exp=%h", o, e); end
        send(32'h1C00_5008, I_BEQ, 1'b0, 1'b1, 1'b1, 32'h1C00_5A00, 1'b1, 32'h1C00_5A00, 1'b0, 1'b0);
        e = exp_q.pop_front(); o = snap(); checks++;
        if (o !== e) begin errors++; $display("FAIL b2b_third got=%h exp=%h", o, e); end
        send(32'h1C00_500C, 32'h0280_0000, 1'b0, 1'b0, 1'b1, 32'h1C00_5F00, 1'b0, 32'h1C00_5F00, 1'b0, 1'b0);
        e = exp_q.pop_front(); o = snap(); checks++;
        if (o !== e) begin errors++; $display("FAIL b2b_nonbranch_idle got=%h exp=%h", o, e); end
    endtask

    task automatic test_saturation();
        obs_t e, o;
        apply_reset();
        @(negedge clk);
        force dut.r_br_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_br_cnt;
        exp_q.push_back(mk(1'b0, 32'd0, I_B, 1'b1, 1'b0, 1'b1, 32'h1C00_6040, 32'h1C00_6000, 32'hFFFF_FFFF, 32'd0));
        send(32'h1C00_6000, I_B, 1'b1, 1'b0, 1'b1, 32'h1C00_6040, 1'b1, 32'h1C00_6040, 1'b0, 1'b0);
        e = exp_q.pop_front(); o = snap(); checks++;
        if (o !== e) begin errors++; $display("FAIL br_cnt_saturate got=%h exp=%h", o, e); end
        exp_q.push_back(mk(1'b1, 32'h0000_0000, I_BEQ, 1'b0, 1'b1, 1'b0, 32'h0000_1000, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 32'd1));
        send(32'hFFFF_FFFC, I_BEQ, 1'b0, 1'b1, 1'b1, 32'h0000_1000, 1'b0, 32'h0000_1000, 1'b0, 1'b0);
        e = exp_q.pop_front(); o = snap(); checks++;
        if (o !== e) begin errors++; $display("FAIL pc_wrap_redirect got=%h exp=%h", o, e); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0;
        clear_inputs();
        test_reset();
        test_btb_miss();
        test_not_taken();
        test_stall();
        test_flush();
        test_back_to_back();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
